// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the MIPS general-purpose register file.
//   REG_W      : register data width (32)
//   NREG       : number of architectural registers (32)
//   ADDR_W     : register address width (5)
//   reg_addr_t : register address type
//   word_t     : register data word type
//   REG_ZERO   : address of the hardwired-zero register r0
// ---------------------------------------------------------------------------
package regfile_pkg;

    localparam int REG_W  = 32;
    localparam int NREG   = 32;
    localparam int ADDR_W = 5;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [REG_W-1:0]  word_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/mux32.sv
// ---------------------------------------------------------------------------
// mux32
// One-bit 32:1 selector used to build each bit of a register read port.
// The tree is three levels deep: eight 4:1 muxes on sel[1:0], two 4:1
// muxes on sel[3:2], and a final 2:1 mux on sel[4].
// Ports:
//   d   : input  [31:0]  the same bit position taken from registers 0..31
//   sel : input  [4:0]   register address
//   y   : output         selected bit
// ---------------------------------------------------------------------------
module mux32 (
    input  logic [31:0] d,
    input  logic [4:0]  sel,
    output logic        y
);

    logic [7:0] level1;
    logic [1:0] level2;

    for (genvar g = 0; g < 8; g++) begin : g_level1
        logic [3:0] group;
        assign group     = d[4*g +: 4];
        assign level1[g] = group[sel[1:0]];
    end

    for (genvar g = 0; g < 2; g++) begin : g_level2
        logic [3:0] group;
        assign group     = level1[4*g +: 4];
        assign level2[g] = group[sel[3:2]];
    end

    assign y = sel[4] ? level2[1] : level2[0];

endmodule

// File: rtl/regfile_read_port.sv
// ---------------------------------------------------------------------------
// regfile_read_port
// One combinational read port of the register file. Bit k of the output is
// produced by its own mux32, fed with bit k of every register.
// Ports:
//   regs : input  [NREG-1:0][REG_W-1:0]  full register array (r0 at index 0)
//   addr : input  [4:0]                  register address
//   data : output [31:0]                 selected register word
// ---------------------------------------------------------------------------
module regfile_read_port
    import regfile_pkg::*;
(
    input  logic [NREG-1:0][REG_W-1:0] regs,
    input  reg_addr_t                  addr,
    output word_t                      data
);

    for (genvar k = 0; k < REG_W; k++) begin : g_bit
        // Gather bit k of every register into one column for the mux.
        logic [NREG-1:0] column;

        for (genvar r = 0; r < NREG; r++) begin : g_col
            assign column[r] = regs[r][k];
        end

        mux32 u_mux (
            .d   (column),
            .sel (addr),
            .y   (data[k])
        );
    end

endmodule

// File: rtl/regfile32.sv
// ---------------------------------------------------------------------------
// regfile32
// 32 x 32-bit MIPS general-purpose register file: two combinational read
// ports and one synchronous write port. r0 always reads zero.
// Optional build macro: REGFILE_BYPASS_EN -- when defined, a read of the
// register being written in the current cycle returns the incoming write
// data instead of the stored value.
// Ports:
//   clk    : input         rising-edge clock
//   reset  : input         asynchronous active-high reset, clears all state
//   we     : input         write enable, sampled at the rising edge
//   ra1    : input  [4:0]  read address, port 1 (rs)
//   ra2    : input  [4:0]  read address, port 2 (rt)
//   wa     : input  [4:0]  write address
//   wd     : input  [31:0] write data
//   rd1    : output [31:0] read data, port 1
//   rd2    : output [31:0] read data, port 2
//   wcount : output [15:0] committed writes to nonzero registers (wraps)
// ---------------------------------------------------------------------------
module regfile32
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    output logic [15:0] wcount
);

    // The mux32 read structure only works for exactly 32 x 32 bits.
    if (WIDTH != REG_W) begin : g_bad_width
        $error("regfile32: WIDTH must be 32");
    end
    if (NREGS != NREG) begin : g_bad_nregs
        $error("regfile32: NREGS must be 32");
    end

    word_t                      store [1:NREG-1];
    logic [NREG-1:0][REG_W-1:0] regs_flat;
    word_t                      port1_data;
    word_t                      port2_data;
    logic                       write_hit;

    // A write only commits when enabled and not aimed at r0.
    assign write_hit = we && (wa != REG_ZERO);

    // r1..r31 storage; r0 has no flop at all.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++) begin
                store[i] <= '0;
            end
        end else if (write_hit) begin
            for (int i = 1; i < NREG; i++) begin
                if (wa == ADDR_W'(i)) begin
                    store[i] <= wd;
                end
            end
        end
    end

    // Debug write counter; wraps silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wcount <= '0;
        end else if (write_hit) begin
            wcount <= wcount + 16'd1;
        end
    end

    // Flatten storage for the read ports with r0 hardwired to zero.
    always_comb begin
        regs_flat[0] = '0;
        for (int i = 1; i < NREG; i++) begin
            regs_flat[i] = store[i];
        end
    end

    regfile_read_port u_port1 (
        .regs (regs_flat),
        .addr (ra1),
        .data (port1_data)
    );

    regfile_read_port u_port2 (
        .regs (regs_flat),
        .addr (ra2),
        .data (port2_data)
    );

`ifdef REGFILE_BYPASS_EN
    // Write-through: forward wd to a port reading the register being written.
    assign rd1 = (write_hit && (ra1 == wa)) ? wd : port1_data;
    assign rd2 = (write_hit && (ra2 == wa)) ? wd : port2_data;
`else
    assign rd1 = port1_data;
    assign rd2 = port2_data;
`endif

endmodule
